// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises multi-byte channel reads/writes onto a
// byte-wide memory port, with flush rollback, global stall and I/O write stall.
module mem_arbiter #(
  parameter int          NUM_CH = 2,
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        req_en,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*3-1:0]      req_len,
  input  logic [NUM_CH*32-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        done,
  output logic [31:0]              rdata,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  localparam int          CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NCH  = NUM_CH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

  state_t            state, state_nx;
  logic [2:0]        k, k_nx;
  logic [CH_W-1:0]   ch_q, last_grant, gnt_ch;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        len_q, sel_len, km1;
  logic [31:0]       wdata_q, rbuf, rdata_q;
  logic              wr_q, gnt_valid, grant, io_space, stall, flush_eff;
  int unsigned       idx;

  generate
    if (ADDR_W >= 18) begin : g_io
      assign io_space = (addr_q[17:16] == IO_HI);
    end else begin : g_no_io
      assign io_space = 1'b0;
    end
  endgenerate

  assign stall     = (state == S_WRITE) && io_space && io_buffer_full;
  assign flush_eff = flush && rdy;
  assign km1       = k - 3'd1;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(last_grant) + 32'd1 + i) % NCH;
      if (!gnt_valid && req_en[idx]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    case (req_len[gnt_ch*3 +: 3])
      3'd1:    sel_len = 3'd1;
      3'd2:    sel_len = 3'd2;
      default: sel_len = 3'd4;
    endcase
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    grant    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && gnt_valid) begin
          grant    = 1'b1;
          k_nx     = 3'd0;
          state_nx = req_wr[gnt_ch] ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (flush) begin
          state_nx = S_IDLE;
          k_nx     = 3'd0;
        end else if (k == len_q) begin
          state_nx = S_FINISH;
        end else begin
          k_nx = k + 3'd1;
        end
      end
      S_WRITE: begin
        if (!stall) begin
          if (k == len_q - 3'd1) state_nx = S_FINISH;
          else                   k_nx     = k + 3'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        k_nx     = 3'd0;
      end
    endcase
  end

  // rdata is exposed from the shadow buffer during an unflushed read FINISH so
  // it is valid alongside done, and committed to rdata_q on leaving FINISH.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    done     = '0;
    rdata    = rdata_q;
    case (state)
      S_READ: begin
        if (k < len_q) mem_a = addr_q + ADDR_W'(k);
      end
      S_WRITE: begin
        mem_a    = addr_q + ADDR_W'(k);
        mem_dout = wdata_q[{k[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !stall;
      end
      S_FINISH: begin
        if (wr_q || !flush_eff) done[ch_q] = 1'b1;
        if (!wr_q && !flush_eff) rdata = rbuf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      k          <= '0;
      ch_q       <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rbuf       <= '0;
      rdata_q    <= '0;
    end else if (rdy) begin
      state <= state_nx;
      k     <= k_nx;
      if (grant) begin
        ch_q       <= gnt_ch;
        last_grant <= gnt_ch;
        addr_q     <= req_addr[gnt_ch*ADDR_W +: ADDR_W];
        len_q      <= sel_len;
        wdata_q    <= req_wdata[gnt_ch*32 +: 32];
        wr_q       <= req_wr[gnt_ch];
        rbuf       <= '0;
      end
      if (state == S_READ && !flush && k != 3'd0)
        rbuf[{km1[1:0], 3'b000} +: 8] <= mem_din;
      if (state == S_FINISH && !wr_q && !flush)
        rdata_q <= rbuf;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (2 channels, 32-bit address).
module tb_mem_arbiter;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic                     clk = 1'b0;
  logic                     rst, rdy, flush, io_buffer_full;
  logic [NUM_CH-1:0]        req_en, req_wr, done;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*3-1:0]      req_len;
  logic [NUM_CH*32-1:0]     req_wdata;
  logic [31:0]              rdata;
  logic [7:0]               mem_din, mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;

  logic [7:0] mem [0:4095];
  int checks = 0;
  int failures = 0;

  mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Memory returns the byte addressed in the previous cycle.
  always @(posedge clk) mem_din <= mem[mem_a[11:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [2:0] len, input logic [31:0] wd);
    req_wr[ch]                  = wr;
    req_addr[ch*ADDR_W +: ADDR_W] = addr;
    req_len[ch*3 +: 3]          = len;
    req_wdata[ch*32 +: 32]      = wd;
  endtask

  logic [1:0]  d_order [0:2];
  int          d_cyc   [0:2];
  logic [31:0] d_rd    [0:2];
  int          nd, n;
  logic [31:0] rd_cap;
  logic [1:0]  dn_cap;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22;
    mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    req_en = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    rst = 1'b1;
    tick();

    // Ch0 read, len 4 at 0x100
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    req_en = 2'b01;
    tick(); #1;
    chk("rd4_a0", mem_a, 32'h100);
    chk("rd4_wr0", mem_wr, 0);
    chk("rd4_done_early", done, 0);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      chk("rd4_a", mem_a, 32'h100 + i);
    end
    tick(); #1;
    chk("rd4_done_k4", done, 0);
    tick(); #1;
    chk("rd4_done", done, 2'b01);
    chk("rd4_rdata", rdata, 32'h44332211);
    req_en = 2'b00;
    tick(); #1;
    chk("rd4_done_drop", done, 0);
    chk("rd4_rdata_hold", rdata, 32'h44332211);

    // Both channels continuously requesting after reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
    set_req(1, 1'b0, 32'h101, 3'd1, 32'h0);
    req_en = 2'b11;
    nd = 0;
    for (int cyc = 0; cyc < 40 && nd < 3; cyc++) begin
      tick(); #1;
      if (done != 0) begin
        d_order[nd] = done; d_cyc[nd] = cyc; d_rd[nd] = rdata;
        nd++;
        if (nd == 3) req_en = 2'b00;
      end
    end
    chk("rr_count", nd, 3);
    if (nd == 3) begin
      chk("rr_g0", d_order[0], 2'b01);
      chk("rr_g1", d_order[1], 2'b10);
      chk("rr_g2", d_order[2], 2'b01);
      chk("rr_rd0", d_rd[0], 32'h11);
      chk("rr_rd1", d_rd[1], 32'h22);
      chk("rr_gap01", d_cyc[1] - d_cyc[0], 4);
      chk("rr_gap12", d_cyc[2] - d_cyc[1], 4);
    end
    tick();

    // Ch1 I/O write stalled by a full buffer for 3 cycles
    set_req(1, 1'b1, 32'h30000, 3'd1, 32'h41);
    io_buffer_full = 1'b1;
    req_en = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("io_stall_wr", mem_wr, 0);
      chk("io_stall_done", done, 0);
    end
    tick();
    io_buffer_full = 1'b0;
    #1;
    chk("io_wr", mem_wr, 1);
    chk("io_dout", mem_dout, 8'h41);
    chk("io_a", mem_a, 32'h30000);
    tick(); #1;
    chk("io_done", done, 2'b10);
    req_en = 2'b00;
    tick();

    // Read len 2 flushed at k=1, then a write running under flush
    set_req(0, 1'b0, 32'h102, 3'd2, 32'h0);
    req_en = 2'b01;
    tick();
    tick();
    flush = 1'b1;
    req_en = 2'b00;
    #1;
    chk("fl_rd_done", done, 0);
    chk("fl_rd_rdata", rdata, 32'h11);
    tick();
    flush = 1'b0;
    set_req(1, 1'b1, 32'h200, 3'd2, 32'hBEEF);
    req_en = 2'b10;
    #1;
    chk("fl_idle_done", done, 0);
    chk("fl_idle_rdata", rdata, 32'h11);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_wr_a0", mem_a, 32'h200);
    chk("fl_wr_d0", mem_dout, 8'hEF);
    chk("fl_wr_wr0", mem_wr, 1);
    tick(); #1;
    chk("fl_wr_a1", mem_a, 32'h201);
    chk("fl_wr_d1", mem_dout, 8'hBE);
    tick(); #1;
    chk("fl_wr_done", done, 2'b10);
    chk("fl_wr_rdata", rdata, 32'h11);
    req_en = 2'b00;
    flush = 1'b0;
    tick();

    // rdy low for 4 cycles at write k=1
    set_req(0, 1'b1, 32'h400, 3'd4, 32'hDDCCBBAA);
    req_en = 2'b01;
    tick(); #1;
    chk("rdy_a0", mem_a, 32'h400);
    chk("rdy_d0", mem_dout, 8'hAA);
    tick();
    rdy = 1'b0;
    #1;
    chk("rdy_frz_wr", mem_wr, 0);
    chk("rdy_frz_a", mem_a, 32'h401);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rdy_frz_wr", mem_wr, 0);
      chk("rdy_frz_a", mem_a, 32'h401);
      chk("rdy_frz_done", done, 0);
    end
    tick();
    rdy = 1'b1;
    #1;
    chk("rdy_res_wr", mem_wr, 1);
    chk("rdy_res_a", mem_a, 32'h401);
    chk("rdy_res_d", mem_dout, 8'hBB);
    tick(); #1;
    chk("rdy_a2", mem_a, 32'h402);
    chk("rdy_d2", mem_dout, 8'hCC);
    tick(); #1;
    chk("rdy_a3", mem_a, 32'h403);
    chk("rdy_d3", mem_dout, 8'hDD);
    tick(); #1;
    chk("rdy_done", done, 2'b01);
    req_en = 2'b00;
    tick();

    // Reset in the middle of a read
    set_req(1, 1'b0, 32'h100, 3'd4, 32'h0);
    req_en = 2'b10;
    repeat (3) tick();
    rst = 1'b0;
    req_en = 2'b00;
    tick(); #1;
    chk("mrst_done", done, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_a", mem_a, 0);
    chk("mrst_wr", mem_wr, 0);
    chk("mrst_dout", mem_dout, 0);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      if (done != 0) n++;
    end
    chk("mrst_no_done", n, 0);

    // Illegal length 3 behaves as 4
    set_req(0, 1'b0, 32'h100, 3'd3, 32'h0);
    req_en = 2'b01;
    n = 0; rd_cap = '0; dn_cap = '0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      tick(); #1;
      if (done != 0) begin
        n = i; rd_cap = rdata; dn_cap = done;
        req_en = 2'b00;
      end
    end
    chk("len3_latency", n, 6);
    chk("len3_done", dn_cap, 2'b01);
    chk("len3_rdata", rd_cap, 32'h44332211);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
